// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array and its operand feeder.
package systolic_pkg;

  localparam int DEFAULT_SIZE     = 3;
  localparam int DEFAULT_IN_WIDTH = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  // Number of array cycles needed for the skewed operands to fully traverse the array.
  function automatic int stream_len(input int size);
    return 3 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand beat handshake plus the skewed stream and controls driven into the array.
interface systolic_feeder_if import systolic_pkg::*; #(
  parameter int SIZE     = DEFAULT_SIZE,
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH
);

  logic                               row_valid;
  logic                               row_ready;
  logic [SIZE-1:0][IN_WIDTH-1:0]      a_row;
  logic [SIZE-1:0][IN_WIDTH-1:0]      b_col;
  logic [SIZE-1:0][IN_WIDTH-1:0]      a_in;
  logic [SIZE-1:0][IN_WIDTH-1:0]      b_in;
  logic                               load_en;
  logic                               mult_en;
  logic                               acc_en;
  logic                               busy;
  logic                               done;

  modport master (
    output row_valid, a_row, b_col,
    input  row_ready, a_in, b_in, load_en, mult_en, acc_en, busy, done
  );

  modport slave (
    input  row_valid, a_row, b_col,
    output row_ready, a_in, b_in, load_en, mult_en, acc_en, busy, done
  );

endinterface

// File: rtl/systolic_operand_buf.sv
// SIZE x SIZE operand register file: one row written per beat, read back along the
// anti-diagonal selected by t so that lane i sees element [i][t-i].
module systolic_operand_buf import systolic_pkg::*; #(
  parameter int SIZE     = DEFAULT_SIZE,
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
  parameter int ROW_W    = $clog2(SIZE + 1),
  parameter int T_W      = $clog2(3 * SIZE - 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [ROW_W-1:0]              wr_idx,
  input  logic [SIZE-1:0][IN_WIDTH-1:0] wr_data,
  input  logic                          rd_en,
  input  logic [T_W-1:0]                rd_t,
  output logic [SIZE-1:0][IN_WIDTH-1:0] rd_data
);

  logic [SIZE-1:0][SIZE-1:0][IN_WIDTH-1:0] mem_r;

  // Row write port; contents persist until the next fill overwrites them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r <= '0;
    end else begin
      for (int k = 0; k < SIZE; k++) begin
        if (wr_en && (wr_idx == ROW_W'(k))) begin
          mem_r[k] <= wr_data;
        end
      end
    end
  end

  // Diagonal read: lanes whose index t-i falls outside the matrix read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (rd_en && (rd_t == T_W'(i + j))) begin
          rd_data[i] = mem_r[i][j];
        end else begin
          rd_data[i] = rd_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A rows and B columns, then drives the skewed operand stream and
// load/mult/acc controls for one systolic product pass.
module systolic_feeder import systolic_pkg::*; #(
  parameter int SIZE     = DEFAULT_SIZE,
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  systolic_feeder_if.slave   bus
);

  localparam int ROW_W = $clog2(SIZE + 1);
  localparam int T_W   = $clog2(3 * SIZE - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE - 1);
  localparam logic [T_W-1:0]   LAST_T   = T_W'(stream_len(SIZE) - 1);

  feeder_state_t                 state_r;
  logic [ROW_W-1:0]              row_cnt_r;
  logic [T_W-1:0]                t_r;
  logic                          row_ready_r;
  logic                          load_en_r;
  logic                          mult_en_r;
  logic                          acc_en_r;
  logic                          busy_r;
  logic                          done_r;
  logic [SIZE-1:0][IN_WIDTH-1:0] a_in_r;
  logic [SIZE-1:0][IN_WIDTH-1:0] b_in_r;

  logic                          wr_en_s;
  logic                          rd_en_s;
  logic [T_W-1:0]                rd_t_s;
  logic [SIZE-1:0][IN_WIDTH-1:0] a_rd_s;
  logic [SIZE-1:0][IN_WIDTH-1:0] b_rd_s;

  assign wr_en_s = (state_r == FILL) && bus.row_valid;

  // Read the diagonal for the upcoming stream step so a_in/b_in can be registered.
  always_comb begin
    rd_en_s = 1'b0;
    rd_t_s  = '0;
    case (state_r)
      LOAD: begin
        rd_en_s = 1'b1;
        rd_t_s  = '0;
      end
      STREAM: begin
        if (t_r != LAST_T) begin
          rd_en_s = 1'b1;
          rd_t_s  = t_r + T_W'(1);
        end else begin
          rd_en_s = 1'b0;
          rd_t_s  = '0;
        end
      end
      default: begin
        rd_en_s = 1'b0;
        rd_t_s  = '0;
      end
    endcase
  end

  systolic_operand_buf #(.SIZE(SIZE), .IN_WIDTH(IN_WIDTH), .ROW_W(ROW_W), .T_W(T_W)) u_a_buf (
    .clk(clk), .reset(reset), .wr_en(wr_en_s), .wr_idx(row_cnt_r), .wr_data(bus.a_row),
    .rd_en(rd_en_s), .rd_t(rd_t_s), .rd_data(a_rd_s)
  );

  systolic_operand_buf #(.SIZE(SIZE), .IN_WIDTH(IN_WIDTH), .ROW_W(ROW_W), .T_W(T_W)) u_b_buf (
    .clk(clk), .reset(reset), .wr_en(wr_en_s), .wr_idx(row_cnt_r), .wr_data(bus.b_col),
    .rd_en(rd_en_s), .rd_t(rd_t_s), .rd_data(b_rd_s)
  );

  // Pass sequencer: state, counters and every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= FILL;
      row_cnt_r   <= '0;
      t_r         <= '0;
      row_ready_r <= 1'b1;
      load_en_r   <= 1'b0;
      mult_en_r   <= 1'b0;
      acc_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      a_in_r      <= '0;
      b_in_r      <= '0;
    end else begin
      a_in_r <= a_rd_s;
      b_in_r <= b_rd_s;
      case (state_r)
        FILL: begin
          if (bus.row_valid) begin
            if (row_cnt_r == LAST_ROW) begin
              state_r     <= LOAD;
              row_cnt_r   <= '0;
              row_ready_r <= 1'b0;
              busy_r      <= 1'b1;
              load_en_r   <= 1'b1;
            end else begin
              row_cnt_r <= row_cnt_r + ROW_W'(1);
            end
          end
        end
        LOAD: begin
          state_r   <= STREAM;
          t_r       <= '0;
          load_en_r <= 1'b0;
          mult_en_r <= 1'b1;
          acc_en_r  <= 1'b1;
        end
        STREAM: begin
          if (t_r == LAST_T) begin
            state_r   <= DONE;
            t_r       <= '0;
            mult_en_r <= 1'b0;
            acc_en_r  <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            t_r <= t_r + T_W'(1);
          end
        end
        DONE: begin
          state_r     <= FILL;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          row_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= FILL;
          row_cnt_r   <= '0;
          t_r         <= '0;
          row_ready_r <= 1'b1;
          load_en_r   <= 1'b0;
          mult_en_r   <= 1'b0;
          acc_en_r    <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.row_ready = row_ready_r;
  assign bus.load_en   = load_en_r;
  assign bus.mult_en   = mult_en_r;
  assign bus.acc_en    = acc_en_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.a_in      = a_in_r;
  assign bus.b_in      = b_in_r;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed, table-driven bench for systolic_feeder with SIZE=3, A=[[1..3],[4..6],[7..9]].
module tb_systolic_feeder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  systolic_feeder_if #(.SIZE(3), .IN_WIDTH(8)) bus ();

  systolic_feeder #(.SIZE(3), .IN_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [23:0] a;
    logic [23:0] b;
    logic [53:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [53:0] mk(input int a0, a1, a2, b0, b1, b2,
                                     input bit ld, mu, ac, dn, bz, rd);
    return {8'(a2), 8'(a1), 8'(a0), 8'(b2), 8'(b1), 8'(b0), ld, mu, ac, dn, bz, rd};
  endfunction

  function automatic logic [53:0] outs();
    return {bus.a_in, bus.b_in, bus.load_en, bus.mult_en, bus.acc_en,
            bus.done, bus.busy, bus.row_ready};
  endfunction

  task automatic check(input string name, input logic [53:0] act, input logic [53:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected trace for the 10 cycles following the accept of the last beat.
  task automatic fill_table(input int bs, input bit garb);
    tbl[0].exp = mk(0, 0, 0, 0, 0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[1].exp = mk(1, 0, 0, bs, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[2].exp = mk(2, 4, 0, 0, 0, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[3].exp = mk(3, 5, 7, 0, bs, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[4].exp = mk(0, 6, 8, 0, 0, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[5].exp = mk(0, 0, 9, 0, 0, bs, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[6].exp = mk(0, 0, 0, 0, 0, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[7].exp = mk(0, 0, 0, 0, 0, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[8].exp = mk(0, 0, 0, 0, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[9].exp = mk(0, 0, 0, 0, 0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 10; r++) begin
      tbl[r].valid = garb;
      tbl[r].a     = garb ? 24'($urandom) : 24'd0;
      tbl[r].b     = garb ? 24'($urandom) : 24'd0;
    end
  endtask

  // Three beats of A and bs*identity, with gap idle cycles between beats.
  task automatic send_fill(input int bs, input int gap, input string tag);
    logic [2:0][7:0] ar;
    logic [2:0][7:0] bc;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_fill_ready%0d", tag, k), {52'd0, bus.busy, bus.row_ready}, 54'd1);
      for (int c = 0; c < 3; c++) begin
        ar[c] = 8'(3 * k + c + 1);
        bc[c] = (c == k) ? 8'(bs) : 8'd0;
      end
      bus.row_valid = 1'b1;
      bus.a_row     = ar;
      bus.b_col     = bc;
      tick();
      if (k < 2) begin
        for (int g = 0; g < gap; g++) begin
          bus.row_valid = 1'b0;
          bus.a_row     = 24'($urandom);
          bus.b_col     = 24'($urandom);
          check($sformatf("%s_gap_hold%0d_%0d", tag, k, g), {52'd0, bus.busy, bus.row_ready}, 54'd1);
          tick();
        end
      end
    end
    bus.row_valid = 1'b0;
  endtask

  task automatic run_table(input int nrows, input string tag);
    for (int r = 0; r < nrows; r++) begin
      check($sformatf("%s_row%0d", tag, r), outs(), tbl[r].exp);
      if (r < nrows - 1) begin
        bus.row_valid = tbl[r].valid;
        bus.a_row     = tbl[r].a;
        bus.b_col     = tbl[r].b;
        tick();
      end
    end
  endtask

  localparam logic [53:0] RESET_EXP = 54'd1;

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.row_valid = 1'b0;
    bus.a_row     = '0;
    bus.b_col     = '0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.row_valid = 1'($urandom);
      bus.a_row     = 24'($urandom);
      bus.b_col     = 24'($urandom);
      tick();
      check($sformatf("reset_hold%0d", i), outs(), RESET_EXP);
    end
    bus.row_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Back-to-back fill and full pass
    fill_table(1, 1'b0);
    send_fill(1, 0, "basic");
    run_table(10, "basic");

    // Gapped fill: row_cnt must hold across idle cycles
    send_fill(1, 2, "gapped");
    run_table(10, "gapped");

    // Garbage beats during LOAD/STREAM/DONE must be ignored
    fill_table(1, 1'b1);
    send_fill(1, 0, "garbage");
    run_table(10, "garbage");
    bus.row_valid = 1'b0;
    fill_table(1, 1'b0);
    send_fill(1, 0, "after_garbage");
    run_table(10, "after_garbage");

    // Reset at stream t=3 aborts the pass immediately
    send_fill(1, 0, "midreset");
    run_table(5, "midreset");
    #1;
    reset = 1'b0;
    #1;
    check("midreset_async", outs(), RESET_EXP);
    tick();
    check("midreset_held", outs(), RESET_EXP);
    reset = 1'b1;
    tick();
    send_fill(1, 0, "post_reset");
    run_table(10, "post_reset");

    // Second fill starts in the first FILL cycle after done
    fill_table(2, 1'b0);
    send_fill(2, 0, "b2b");
    run_table(10, "b2b");
    bus.row_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
